// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: registered 8-requester arbiter with one-hot grant, encoded grant id
// and a hold-timeout that preempts an owner hogging the resource while others wait.
// Build option: define ARB_FIXED_PRI_EN for fixed priority (req[7] highest) instead
// of round-robin selection.
//
// Handshake: req[i] is a level, not a pulse. Client i owns the resource while gnt[i]
// is high and keeps req[i] high for as long as it needs it. The owner releases by
// dropping req[i]; the release, any handover and any new grant all take effect at
// the next rising edge. Every output is a flop, so req never reaches an output
// combinationally.
module rr_arbiter_8 #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter saturation value and the count at which a contended owner is forced off.
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [2:0]       id_nxt;
  logic             valid_nxt;
  logic             pre_nxt;
  logic [N_REQ-1:0] cand;
  logic             do_grant;
  logic             timeout;
  logic [2:0]       win;

`ifdef ARB_FIXED_PRI_EN
  // Highest set index wins; the rotation pointer plays no part.
  function automatic logic [2:0] select_winner(input logic [N_REQ-1:0] c,
                                               input logic [2:0]       start);
    logic [2:0] w;
    w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (c[k]) w = 3'(k);
    end
    return w;
  endfunction
`else
  // First set bit scanning upward from start, wrapping modulo 8.
  function automatic logic [2:0] select_winner(input logic [N_REQ-1:0] c,
                                               input logic [2:0]       start);
    logic [2:0] w;
    logic [2:0] idx;
    logic       found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = start + 3'(k);
      if (!found && c[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction
`endif

  // A contended owner is forced off once it has used its hold budget. The compare is
  // >= so that an owner whose counter saturated while alone is still preempted as soon
  // as a contender shows up.
  assign timeout = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST) && (|(req & ~gnt));

  // Next-state, next-grant and counter logic; a single selection path serves the
  // idle grant, the release handover and the timeout preemption.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    valid_nxt = gnt_valid;
    pre_nxt   = 1'b0;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    cand      = '0;
    do_grant  = 1'b0;
    win       = '0;

    case (state)
      IDLE: begin
        if (|req) begin
          cand     = req;
          do_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          if (|req) begin
            // Zero-bubble handover straight from the old owner to the new one.
            cand     = req;
            do_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            id_nxt    = '0;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
          end
        end else if (timeout) begin
          // The owner is excluded from this one selection only.
          cand     = req & ~gnt;
          do_grant = 1'b1;
          pre_nxt  = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (do_grant) begin
      win       = select_winner(cand, ptr);
      state_nxt = GRANT;
      gnt_nxt   = N_REQ'(1) << win;
      id_nxt    = win;
      valid_nxt = 1'b1;
      cnt_nxt   = '0;
`ifdef ARB_FIXED_PRI_EN
      ptr_nxt   = '0;
`else
      ptr_nxt   = win + 3'd1;
`endif
    end
  end

  // State, pointer, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
      preempt   <= pre_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed scenarios plus random request traffic for rr_arbiter_8,
// scored every cycle against a behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {preempt, gnt_valid, gnt_id, gnt}, one entry per clock edge.
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  // Model state: owner index (-1 idle), rotation start, grant cycles used so far.
  int         m_owner  = -1;
  int         m_ptr    = 0;
  int         m_cycles = 0;
  logic       m_pre    = 1'b0;
  logic [7:0] m_others;

  rr_arbiter_8 #(.N_REQ(8), .MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [7:0] cand, input int from);
`ifdef ARB_FIXED_PRI_EN
    for (int i = 7; i >= 0; i--) if (cand[i]) return i;
`else
    for (int k = 0; k < 8; k++) if (cand[(from + k) % 8]) return (from + k) % 8;
`endif
    return -1;
  endfunction

  task automatic grant_to(input int w);
    m_owner  = w;
    m_cycles = 1;
`ifndef ARB_FIXED_PRI_EN
    m_ptr    = (w + 1) % 8;
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_cycles = 0;
      m_pre    = 1'b0;
      exp_q.delete();
    end else begin
      m_pre = 1'b0;
      if (m_owner < 0) begin
        if (req != 8'h00) grant_to(pick(req, m_ptr));
      end else if (!req[m_owner]) begin
        if (req != 8'h00) grant_to(pick(req, m_ptr));
        else m_owner = -1;
      end else begin
        m_others = req;
        m_others[m_owner] = 1'b0;
        if (MAX_HOLD > 0 && m_cycles >= MAX_HOLD && m_others != 8'h00) begin
          grant_to(pick(m_others, m_ptr));
          m_pre = 1'b1;
        end else begin
          m_cycles++;
        end
      end
      if (m_owner < 0) exp_q.push_back({m_pre, 1'b0, 3'd0, 8'd0});
      else exp_q.push_back({m_pre, 1'b1, 3'(m_owner), 8'(1 << m_owner)});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else mon_e = '0;
      check_val("sb_gnt",       gnt,       mon_e[7:0]);
      check_val("sb_gnt_id",    gnt_id,    mon_e[10:8]);
      check_val("sb_gnt_valid", gnt_valid, mon_e[11]);
      check_val("sb_preempt",   preempt,   mon_e[12]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_gnt"},     gnt,       0);
    check_val({tag, "_gnt_id"},  gnt_id,    0);
    check_val({tag, "_valid"},   gnt_valid, 0);
    check_val({tag, "_preempt"}, preempt,   0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = 8'h00;
    #1 check_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] oh;
    logic [7:0] nr;
    int         bit_i;
    int         sel;

    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("rst_init");

    // Single request: 1-cycle latency, then release back to idle.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h04;
    step(8'h04);
    check_val("single_gnt",    gnt,       8'h04);
    check_val("single_id",     gnt_id,    2);
    check_val("single_valid",  gnt_valid, 1);
    step(8'h00);
    step(8'h00);
    check_val("release_gnt",   gnt,       8'h00);
    check_val("release_valid", gnt_valid, 0);

`ifndef ARB_FIXED_PRI_EN
    // Rotation: all requesting, each owner drops for one cycle after two grant cycles.
    apply_reset();
    step(8'hFF);
    for (int k = 0; k <= 8; k++) begin
      oh = 8'(1 << (k % 8));
      step(8'hFF);
      check_val("rot_first", gnt, oh);
      step(8'hFF & ~oh);
      check_val("rot_hold", gnt, oh);
    end

    // Wrap-around: after a grant to 7 the pointer is 0, so 0 beats 7.
    apply_reset();
    step(8'h80);
    step(8'h00);
    check_val("wrap_g7", gnt, 8'h80);
    step(8'h81);
    check_val("wrap_idle", gnt_valid, 0);
    step(8'h81);
    check_val("wrap_gnt", gnt, 8'h01);
    check_val("wrap_id",  gnt_id, 0);
    step(8'h00);
`endif

    // Timeout: owner 3 holds, requester 5 joins in grant cycle 1.
    apply_reset();
    step(8'h08);
    for (int i = 1; i <= 4; i++) begin
      step(8'h28);
      check_val("to_hold_gnt", gnt, 8'h08);
      check_val("to_hold_pre", preempt, 0);
    end
    step(8'h28);
    check_val("to_switch_gnt", gnt, 8'h20);
    check_val("to_switch_pre", preempt, 1);
    step(8'h00);
    check_val("to_after_gnt", gnt, 8'h20);
    check_val("to_after_pre", preempt, 0);
    step(8'h00);

    // Solo owner well past the hold budget: never preempted.
    step(8'h10);
    for (int i = 0; i < 20; i++) begin
      step(8'h10);
      check_val("solo_gnt", gnt, 8'h10);
      check_val("solo_pre", preempt, 0);
    end

    // Asynchronous reset mid-grant, then restart from pointer 0.
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'hFF;
    step(8'hFF);
`ifdef ARB_FIXED_PRI_EN
    check_val("rst_restart_id", gnt_id, 7);
`else
    check_val("rst_restart_id", gnt_id, 0);
`endif
    step(8'h00);

`ifdef ARB_FIXED_PRI_EN
    // Fixed priority: highest index wins, then the next highest on release.
    apply_reset();
    step(8'h2A);
    step(8'h2A);
    check_val("fixed_first_id", gnt_id, 5);
    step(8'h0A);
    step(8'h0A);
    check_val("fixed_next_id", gnt_id, 3);
    step(8'h00);
`endif

    // Random traffic: mostly held requests so holds and timeouts occur.
    for (int c = 0; c < 700; c++) begin
      sel = $urandom_range(0, 9);
      nr  = req;
      if (sel >= 6 && sel < 9) begin
        bit_i = $urandom_range(0, 7);
        nr[bit_i] = ~nr[bit_i];
      end else if (sel == 9) begin
        nr = 8'($urandom_range(0, 255));
      end
      step(nr);
      if (c == 350) begin
        #2 rst_n = 1'b0;
        #1 check_zero("rst_rand");
        #2 rst_n = 1'b1;
      end
    end

    step(8'h00);
    step(8'h00);
    step(8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
